// File: rtl/chacha_ks_xor_stream_if.sv
// chacha_ks_xor_stream_if: keystream, payload and result streams of the ChaCha keystream XOR stage
interface chacha_ks_xor_stream_if;
  logic         start;
  logic         ks_req;
  logic         ks_valid;
  logic [511:0] ks_data;
  logic         in_valid;
  logic [127:0] in_data;
  logic [15:0]  in_keep;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic [15:0]  out_keep;
  logic         out_last;
  logic         out_ready;
  logic [31:0]  ks_blocks;
  modport slave (
    input  start, ks_valid, ks_data, in_valid, in_data, in_keep, in_last, out_ready,
    output ks_req, in_ready, out_valid, out_data, out_keep, out_last, ks_blocks
  );
  modport master (
    output start, ks_valid, ks_data, in_valid, in_data, in_keep, in_last, out_ready,
    input  ks_req, in_ready, out_valid, out_data, out_keep, out_last, ks_blocks
  );
endinterface

// File: rtl/chacha_ks_xor_stream.sv
// chacha_ks_xor_stream: buffers one 512-bit keystream block and XORs it word by word onto a 128-bit stream
module chacha_ks_xor_stream (
  input logic clk,
  input logic rst,
  chacha_ks_xor_stream_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMPTY, WAIT, FULL} state_t;
  state_t            r_state;
  logic [3:0][127:0] r_buf;
  logic [1:0]        r_ptr;
  logic              r_discard;
  logic              r_out_valid;
  logic [127:0]      r_out_data;
  logic [15:0]       r_out_keep;
  logic              r_out_last;
  logic [31:0]       r_ks_blocks;
  logic [127:0]      w_mask;
  logic              w_in_ready;
  logic              w_accept;
  for (genvar i = 0; i < 16; i++) begin : g_mask
    assign w_mask[8*i +: 8] = {8{bus.in_keep[i]}};
  end
  assign w_in_ready    = r_state == FULL && !bus.start && (!r_out_valid || bus.out_ready);
  assign w_accept      = bus.in_valid && w_in_ready;
  assign bus.ks_req    = r_state == EMPTY;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_keep  = r_out_keep;
  assign bus.out_last  = r_out_last;
  assign bus.ks_blocks = r_ks_blocks;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_ptr       <= '0;
      r_discard   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_ks_blocks <= '0;
    end else if (bus.start) begin
      // a request still in flight will return a stale block that must be dropped
      r_state     <= EMPTY;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_ks_blocks <= '0;
      if (r_state == WAIT) r_discard <= 1'b1;
    end else begin
      r_out_valid <= w_accept || (r_out_valid && !bus.out_ready);
      if (w_accept) begin
        r_out_data <= (bus.in_data ^ r_buf[r_ptr]) & w_mask;
        r_out_keep <= bus.in_keep;
        r_out_last <= bus.in_last;
        r_ptr      <= r_ptr + 2'd1;
      end
      case (r_state)
        EMPTY: r_state <= WAIT;
        WAIT: if (bus.ks_valid) begin
          if (r_discard) begin
            r_discard <= 1'b0;
            r_state   <= EMPTY;
          end else begin
            r_buf   <= bus.ks_data;
            r_ptr   <= '0;
            r_state <= FULL;
          end
        end
        FULL: if (w_accept && (r_ptr == 2'd3 || bus.in_last)) begin
          r_state     <= EMPTY;
          r_ks_blocks <= r_ks_blocks + 32'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_ks_xor_stream.sv
// tb_chacha_ks_xor_stream: directed vectors with a queue scoreboard checked by a separate output monitor
module tb_chacha_ks_xor_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  chacha_ks_xor_stream_if bus();
  chacha_ks_xor_stream dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;
  beat_t q[$];
  beat_t m_e;
  int    checks = 0;
  int    errors = 0;
  int    req_cnt = 0;
  bit    cnt_en = 1'b0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  function automatic logic [511:0] mk(input logic [7:0] b);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = b + 8'(k);
    return r;
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h want none", bus.out_data);
      end else begin
        m_e = q.pop_front();
        chk("out_data", bus.out_data, m_e.d);
        chk("out_keep", 128'(bus.out_keep), 128'(m_e.k));
        chk("out_last", 128'(bus.out_last), 128'(m_e.l));
      end
    end
    if (cnt_en && bus.ks_req) req_cnt++;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask
  task automatic give_ks(input logic [511:0] d, input int dly);
    repeat (dly) cyc();
    bus.ks_valid = 1'b1;
    bus.ks_data  = d;
    cyc();
    bus.ks_valid = 1'b0;
  endtask
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l, input logic [127:0] e);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_last  = l;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) chk("in_ready_timeout", 128'(ok), 128'd1);
    else q.push_back({e, k, l});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 0; bus.ks_valid = 0; bus.ks_data = '0; bus.in_valid = 0;
    bus.in_data = '0; bus.in_keep = '0; bus.in_last = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_data", bus.out_data, 128'd0);
    chk("rst_out_keep", 128'(bus.out_keep), 128'd0);
    chk("rst_out_last", 128'(bus.out_last), 128'd0);
    chk("rst_ks_blocks", 128'(bus.ks_blocks), 128'd0);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      chk("idle_ks_req", 128'(bus.ks_req), 128'd0);
      chk("idle_in_ready", 128'(bus.in_ready), 128'd0);
      chk("idle_out_valid", 128'(bus.out_valid), 128'd0);
      cyc();
    end
    bus.in_valid = 1'b0;
    pulse_start();
    chk("start_ks_req_t1", 128'(bus.ks_req), 128'd1);
    cyc();
    chk("start_ks_req_t2", 128'(bus.ks_req), 128'd0);
    give_ks(mk(8'h00), 2);
    send_beat('0, 16'hFFFF, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100);
    send_beat('0, 16'hFFFF, 1'b0, 128'h1f1e1d1c1b1a19181716151413121110);
    send_beat('0, 16'hFFFF, 1'b0, 128'h2f2e2d2c2b2a29282726252423222120);
    send_beat('0, 16'hFFFF, 1'b0, 128'h3f3e3d3c3b3a39383736353433323130);
    chk("full_ks_req_next", 128'(bus.ks_req), 128'd1);
    chk("full_ks_blocks", 128'(bus.ks_blocks), 128'd1);
    give_ks(mk(8'h40), 1);
    send_beat({16{8'hFF}}, 16'h0007, 1'b1, 128'h00bdbebf);
    chk("part_ks_req_next", 128'(bus.ks_req), 128'd1);
    chk("part_ks_blocks", 128'(bus.ks_blocks), 128'd2);
    give_ks(mk(8'h80), 1);
    bus.out_ready = 1'b0;
    send_beat({16{8'hFF}}, 16'hFFFF, 1'b0, 128'h707172737475767778797a7b7c7d7e7f);
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
      @(posedge clk);
    end
    #1 bus.out_ready = 1'b1;
    send_beat('0, 16'hFFFF, 1'b0, 128'h9f9e9d9c9b9a99989796959493929190);
    send_beat({16{8'hFF}}, 16'hFFFF, 1'b0, 128'h505152535455565758595a5b5c5d5e5f);
    send_beat('0, 16'hFFFF, 1'b0, 128'hbfbebdbcbbbab9b8b7b6b5b4b3b2b1b0);
    chk("bp_ks_blocks", 128'(bus.ks_blocks), 128'd3);
    chk("bp_ks_req_next", 128'(bus.ks_req), 128'd1);
    repeat (3) cyc();
    chk("bp_drained", 128'(q.size()), 128'd0);
    pulse_start();
    cyc();
    cnt_en = 1'b1;
    pulse_start();
    chk("stale_ks_blocks", 128'(bus.ks_blocks), 128'd0);
    cyc();
    give_ks({64{8'hAA}}, 1);
    give_ks({64{8'h55}}, 2);
    cnt_en = 1'b0;
    chk("stale_req_cnt", 128'(req_cnt), 128'd2);
    send_beat('0, 16'hFFFF, 1'b1, {16{8'h55}});
    chk("stale_ks_blocks_after", 128'(bus.ks_blocks), 128'd1);
    give_ks(mk(8'h00), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = {16{8'h33}};
    bus.in_keep  = 16'hFFFF;
    bus.in_last  = 1'b0;
    bus.start    = 1'b1;
    #1;
    chk("sim_in_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("sim_out_valid", 128'(bus.out_valid), 128'd0);
    chk("sim_ks_blocks", 128'(bus.ks_blocks), 128'd0);
    chk("sim_ks_req", 128'(bus.ks_req), 128'd1);
    repeat (3) cyc();
    chk("final_queue_empty", 128'(q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chacha_ks_xor_stream.md
# chacha_ks_xor_stream

Keystream-application stage for the ChaCha20 datapath. Consumes 512-bit keystream blocks from the ChaCha keystream unit via its `ks_req`/`ks_valid`/`ks_data` handshake and XORs them onto a 128-bit valid/ready payload stream, one 128-bit word per beat. Its output stream (ciphertext on encrypt, plaintext on decrypt) feeds the Poly1305 adapter's `pld_*` port and the external data path. It owns keystream buffering, word sequencing, byte masking and re-request timing.

## Interface
- No parameters.
- `clk` in 1 — system clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — one-cycle pulse; discards any buffered or in-flight keystream and begins a new message.
- `ks_req` out 1 — one-cycle request for the next keystream block.
- `ks_valid` in 1 — keystream block valid, one-cycle pulse.
- `ks_data` in 512 — keystream block. Byte k is at [8k+7:8k].
- `in_valid` in 1 — payload beat valid.
- `in_data` in 128 — payload. Byte i is at [8i+7:8i].
- `in_keep` in 16 — byte enables, contiguous from bit 0.
- `in_last` in 1 — final beat of the message.
- `in_ready` out 1 — payload beat accepted when `in_valid && in_ready`.
- `out_valid` out 1 — result beat valid.
- `out_data` out 128 — XOR result; bytes with keep=0 are forced to 0.
- `out_keep` out 16 — copy of `in_keep`.
- `out_last` out 1 — copy of `in_last`.
- `out_ready` in 1 — downstream accept.
- `ks_blocks` out 32 — number of keystream blocks consumed since `start`. Wraps modulo 2^32.

## Operation
- States:
  - IDLE: after reset.
  - EMPTY: buffer empty; `ks_req` is high in this state.
  - WAIT: request outstanding.
  - FULL: buffer holds a block.
- Transitions:
  - `start` (any state) → EMPTY.
  - EMPTY → WAIT unconditionally.
  - WAIT + `ks_valid` → FULL: `ks_data` captured, `ptr`=0.
  - FULL + accepted beat with (`ptr`==3 or `in_last`) → EMPTY. `ks_blocks` increments on this transition.
  - Otherwise hold.
- `ks_req` = (state==EMPTY), so it is exactly one cycle per block.
- Word select: `word[ptr]` = `ks_data_buf[128*ptr+127 : 128*ptr]`.
- Accepting a beat:
  - `out_data` ← (`in_data` ^ `word[ptr]`) masked bytewise by `in_keep`.
  - `out_keep`/`out_last` registered from the input.
  - `ptr` ← `ptr`+1 (2-bit).
- `in_last` discards the unused remainder of the block. The next message starts on a fresh block.
- A partial-keep beat that is not `in_last` still consumes a full 128-bit word.
- `in_ready` = (state==FULL) && !`start` && (!`out_valid` || `out_ready`).
- Output register:
  - `out_valid` sets on accept.
  - It clears on `out_ready` without a new accept.
  - Accept and drain in the same cycle keep `out_valid`=1 with new data.
- `ks_valid` outside WAIT is ignored.
- `start` while in WAIT sets `discard`. The first subsequent `ks_valid` is dropped (stale block), `discard` clears, and a new request is issued: state → EMPTY.
- `start` also:
  - clears `out_valid`,
  - clears `ks_blocks`,
  - clears `ptr`.
- `start` and accept in the same cycle: `start` wins and the beat is not accepted (`in_ready`=0).
- `start` and `ks_valid` in the same cycle: the block is dropped.

## Timing
- Reset values:
  - state IDLE,
  - `ks_req`=0, `in_ready`=0, `out_valid`=0,
  - `out_data`=0, `out_keep`=0, `out_last`=0,
  - `ks_blocks`=0, `ptr`=0, `discard`=0.
- `start` at cycle t: state EMPTY at t+1, `ks_req` high at t+1 only, WAIT at t+2.
- `ks_valid` at w: FULL at w+1, `in_ready` high at w+1 if the output slot is free.
- Accept at a: `out_valid` high at a+1.
- Last-word accept at a: EMPTY and `ks_req` at a+1.
- Sustained throughput is 1 beat/cycle within a block. Refill costs 2 cycles plus keystream latency.
- Reset mid-operation: all state returns to reset values asynchronously. A pending keystream is not tracked; `start` is required to resume.

## Test plan
- **Reset/idle:** assert `rst`, release, hold `in_valid`=1 for 20 cycles → `ks_req`, `in_ready` and `out_valid` stay 0.
- **Full block:**
  - Stimulus: `start`; respond to `ks_req` after 3 cycles with `ks_data` = bytes 0x00..0x3F; send 4 beats of `in_data`=0, keep=0xFFFF, `out_ready`=1.
  - Required: outputs equal `ks_data[127:0]`, `[255:128]`, `[383:256]`, `[511:384]` on consecutive cycles; `ks_blocks`=1; a second `ks_req` one cycle after the 4th accept.
- **Partial last beat:**
  - Stimulus: 5 beats, 5th with keep=0x0007 and `in_last`, data 0xFF bytes.
  - Required: `out_data[23:0]` = ~ks bytes 0x40..0x42 of block 2; upper bytes 0; `out_last`=1; `ks_blocks`=2; new `ks_req` next cycle.
- **Backpressure:** `out_ready`=0 for 5 cycles mid-block → `in_ready` low after one accept, no data lost or duplicated, `ptr` resumes correctly.
- **Stale keystream:**
  - Stimulus: `start`, then `start` again while in WAIT, then a `ks_valid` with pattern A followed by a `ks_valid` with pattern B.
  - Required: A ignored; B used for the first output; exactly two `ks_req` pulses after the second `start`.
- **Simultaneous `start` and accept:** `start` coincides with a valid beat in FULL → `in_ready`=0 that cycle, no `out_valid` next cycle, `ks_blocks`=0.
